// File: rtl/rram_cmd_arb.sv
// Round-robin arbiter between host and scrub command sources for a single RRAM FSM.
// Optional launch-acknowledge timeout is enabled by defining RRAM_CMD_ARB_TIMEOUT_EN.
module rram_cmd_arb #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned OP_W      = 3,
   parameter int unsigned TO_CYCLES = 1023
) (
   input  logic              mclk,
   input  logic              rst,
   input  logic              h_req,
   input  logic [OP_W-1:0]   h_opcode,
   input  logic [ADDR_W-1:0] h_addr_start,
   input  logic [ADDR_W-1:0] h_addr_stop,
   input  logic              h_multi,
   output logic              h_gnt,
   output logic              h_done,
   input  logic              s_req,
   input  logic [OP_W-1:0]   s_opcode,
   input  logic [ADDR_W-1:0] s_addr_start,
   input  logic [ADDR_W-1:0] s_addr_stop,
   input  logic              s_multi,
   output logic              s_gnt,
   output logic              s_done,
   input  logic              rram_busy,
   output logic              fsm_go,
   output logic [OP_W-1:0]   opcode,
   output logic [ADDR_W-1:0] address_start,
   output logic [ADDR_W-1:0] address_stop,
   output logic              use_multi_addrs,
   output logic              owner,
   input  logic              err_clr,
   output logic              err_timeout
);

   typedef enum logic [2:0] {StIdle, StLaunch, StWaitAck, StRun, StFinish} state_e;

   state_e state_q;
   logic   last_q;  // 1: scrub was served last
   logic   any_req;
   logic   win;

   always_comb begin
      any_req = h_req | s_req;
      win     = (h_req & s_req) ? ~last_q : s_req;
   end

`ifdef RRAM_CMD_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);
   logic [15:0] cnt_q;
   logic        to_hit;

   assign to_hit = (state_q == StWaitAck) && !rram_busy && (cnt_q == TO_LAST);
`else
   logic unused_cfg;

   assign unused_cfg  = ^{err_clr, TO_CYCLES[0]};
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge mclk) begin
      if (rst) begin
         state_q         <= StIdle;
         last_q          <= 1'b1;
         h_gnt           <= 1'b0;
         s_gnt           <= 1'b0;
         h_done          <= 1'b0;
         s_done          <= 1'b0;
         fsm_go          <= 1'b0;
         opcode          <= '0;
         address_start   <= '0;
         address_stop    <= '0;
         use_multi_addrs <= 1'b0;
         owner           <= 1'b0;
`ifdef RRAM_CMD_ARB_TIMEOUT_EN
         cnt_q           <= '0;
         err_timeout     <= 1'b0;
`endif
      end else begin
         h_gnt  <= 1'b0;
         s_gnt  <= 1'b0;
         h_done <= 1'b0;
         s_done <= 1'b0;
         fsm_go <= 1'b0;
         case (state_q)
            StIdle: begin
               if (any_req && !rram_busy) begin
                  owner           <= win;
                  opcode          <= win ? s_opcode     : h_opcode;
                  address_start   <= win ? s_addr_start : h_addr_start;
                  address_stop    <= win ? s_addr_stop  : h_addr_stop;
                  use_multi_addrs <= win ? s_multi      : h_multi;
                  h_gnt           <= ~win;
                  s_gnt           <= win;
                  state_q         <= StLaunch;
               end
            end
            StLaunch: begin
               fsm_go  <= 1'b1;
               state_q <= StWaitAck;
            end
            StWaitAck: begin
               if (rram_busy) begin
                  state_q <= StRun;
               end
`ifdef RRAM_CMD_ARB_TIMEOUT_EN
               else if (to_hit) begin
                  // Abandon the launch: report completion so the requester is not stranded.
                  h_done  <= ~owner;
                  s_done  <= owner;
                  last_q  <= owner;
                  state_q <= StIdle;
               end
`endif
            end
            StRun: begin
               if (!rram_busy) begin
                  h_done  <= ~owner;
                  s_done  <= owner;
                  state_q <= StFinish;
               end
            end
            StFinish: begin
               last_q  <= owner;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
`ifdef RRAM_CMD_ARB_TIMEOUT_EN
         if (state_q == StWaitAck && !rram_busy && !to_hit) begin
            cnt_q <= cnt_q + 16'd1;
         end else begin
            cnt_q <= '0;
         end
         // A timeout in the same cycle as a clear wins.
         if (to_hit) begin
            err_timeout <= 1'b1;
         end else if (err_clr) begin
            err_timeout <= 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_rram_cmd_arb.sv
// Self-checking bench for rram_cmd_arb: vector table, randomized transactions, corner sequences.
module tb_rram_cmd_arb;

   localparam int unsigned ADDR_W    = 16;
   localparam int unsigned OP_W      = 3;
   localparam int unsigned TO_CYCLES = 8;

   typedef struct {
      logic [OP_W-1:0]   op;
      logic [ADDR_W-1:0] a0;
      logic [ADDR_W-1:0] a1;
      logic              multi;
   } cmd_t;

   typedef struct {
      bit   hr;
      bit   sr;
      cmd_t hc;
      cmd_t sc;
      bit   exp_own;
      cmd_t exp_cmd;
   } vec_t;

   logic              mclk = 1'b0;
   logic              rst;
   logic              h_req, s_req;
   logic [OP_W-1:0]   h_opcode, s_opcode;
   logic [ADDR_W-1:0] h_addr_start, h_addr_stop, s_addr_start, s_addr_stop;
   logic              h_multi, s_multi;
   logic              h_gnt, s_gnt, h_done, s_done;
   logic              rram_busy, fsm_go;
   logic [OP_W-1:0]   opcode;
   logic [ADDR_W-1:0] address_start, address_stop;
   logic              use_multi_addrs, owner, err_clr, err_timeout;

   int n_chk;
   int n_fail;
   bit last;  // model: 1 when scrub was served last
   vec_t vec [8];

   rram_cmd_arb #(
      .ADDR_W(ADDR_W),
      .OP_W(OP_W),
      .TO_CYCLES(TO_CYCLES)
   ) dut (
      .mclk(mclk),
      .rst(rst),
      .h_req(h_req),
      .h_opcode(h_opcode),
      .h_addr_start(h_addr_start),
      .h_addr_stop(h_addr_stop),
      .h_multi(h_multi),
      .h_gnt(h_gnt),
      .h_done(h_done),
      .s_req(s_req),
      .s_opcode(s_opcode),
      .s_addr_start(s_addr_start),
      .s_addr_stop(s_addr_stop),
      .s_multi(s_multi),
      .s_gnt(s_gnt),
      .s_done(s_done),
      .rram_busy(rram_busy),
      .fsm_go(fsm_go),
      .opcode(opcode),
      .address_start(address_start),
      .address_stop(address_stop),
      .use_multi_addrs(use_multi_addrs),
      .owner(owner),
      .err_clr(err_clr),
      .err_timeout(err_timeout)
   );

   always #5 mclk = ~mclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic cmd_t mk(input int op, input int a0, input int a1, input bit m);
      cmd_t c;
      c.op    = OP_W'(op);
      c.a0    = ADDR_W'(a0);
      c.a1    = ADDR_W'(a1);
      c.multi = m;
      return c;
   endfunction

   function automatic cmd_t rand_cmd();
      return mk(int'($urandom), int'($urandom), int'($urandom), bit'($urandom));
   endfunction

   task automatic drive_cmds(input cmd_t hc, input cmd_t sc);
      h_opcode = hc.op; h_addr_start = hc.a0; h_addr_stop = hc.a1; h_multi = hc.multi;
      s_opcode = sc.op; s_addr_start = sc.a0; s_addr_stop = sc.a1; s_multi = sc.multi;
   endtask

   task automatic chk_cmd(input string nm, input cmd_t e);
      chkw({nm, "_opcode"}, 32'(opcode), 32'(e.op));
      chkw({nm, "_addr_start"}, 32'(address_start), 32'(e.a0));
      chkw({nm, "_addr_stop"}, 32'(address_stop), 32'(e.a1));
      chk1({nm, "_multi"}, use_multi_addrs, e.multi);
   endtask

   task automatic chk_all_zero(input string nm);
      chk1({nm, "_h_gnt"}, h_gnt, 1'b0);
      chk1({nm, "_s_gnt"}, s_gnt, 1'b0);
      chk1({nm, "_h_done"}, h_done, 1'b0);
      chk1({nm, "_s_done"}, s_done, 1'b0);
      chk1({nm, "_fsm_go"}, fsm_go, 1'b0);
      chk1({nm, "_owner"}, owner, 1'b0);
      chk1({nm, "_err"}, err_timeout, 1'b0);
      chk_cmd(nm, mk(0, 0, 0, 1'b0));
   endtask

   task automatic do_reset();
      rst = 1'b1; h_req = 1'b0; s_req = 1'b0; rram_busy = 1'b0; err_clr = 1'b0;
      drive_cmds(rand_cmd(), rand_cmd());
      @(negedge mclk);
      chk_all_zero("reset");
      @(negedge mclk);
      rst = 1'b0;
      last = 1'b1;
   endtask

   // Full transaction from IDLE: request, grant, launch, busy handshake, done.
   task automatic run_op(input bit hr, input bit sr, input cmd_t hc, input cmd_t sc, input bit win,
                         input int pre, input int d1, input int d2, input string nm);
      cmd_t ec;
      ec = win ? sc : hc;
      drive_cmds(hc, sc);
      h_req = hr; s_req = sr;
      if (pre > 0) begin
         rram_busy = 1'b1;
         repeat (pre) begin
            @(negedge mclk);
            chk1({nm, "_busy_no_gnt"}, h_gnt | s_gnt, 1'b0);
         end
         rram_busy = 1'b0;
      end
      @(negedge mclk);
      chk1({nm, "_h_gnt"}, h_gnt, !win);
      chk1({nm, "_s_gnt"}, s_gnt, win);
      chk1({nm, "_owner"}, owner, win);
      chk_cmd({nm, "_latch"}, ec);
      h_req = 1'b0; s_req = 1'b0;
      drive_cmds(rand_cmd(), rand_cmd());
      @(negedge mclk);
      chk1({nm, "_fsm_go"}, fsm_go, 1'b1);
      repeat (d1) @(negedge mclk);
      rram_busy = 1'b1;
      repeat (d2) begin
         @(negedge mclk);
         chk1({nm, "_early_done"}, h_done | s_done, 1'b0);
         chk_cmd({nm, "_stable"}, ec);
      end
      rram_busy = 1'b0;
      @(negedge mclk);
      chk1({nm, "_h_done"}, h_done, !win);
      chk1({nm, "_s_done"}, s_done, win);
      @(negedge mclk);
      chk1({nm, "_done_pulse"}, h_done | s_done, 1'b0);
   endtask

   task automatic timeout_test(input bit hold_clr, input string nm);
      drive_cmds(rand_cmd(), rand_cmd());
      h_req = 1'b1; err_clr = hold_clr;
      @(negedge mclk);
      chk1({nm, "_h_gnt"}, h_gnt, 1'b1);
      h_req = 1'b0;
      @(negedge mclk);
      chk1({nm, "_fsm_go"}, fsm_go, 1'b1);
`ifdef RRAM_CMD_ARB_TIMEOUT_EN
      repeat (TO_CYCLES - 1) begin
         @(negedge mclk);
         chk1({nm, "_early_done"}, h_done, 1'b0);
         chk1({nm, "_early_err"}, err_timeout, 1'b0);
      end
      @(negedge mclk);
      chk1({nm, "_h_done"}, h_done, 1'b1);
      chk1({nm, "_err_set"}, err_timeout, 1'b1);
      if (!hold_clr) begin
         @(negedge mclk);
         chk1({nm, "_err_sticky"}, err_timeout, 1'b1);
      end
      err_clr = 1'b1;
      @(negedge mclk);
      chk1({nm, "_err_cleared"}, err_timeout, 1'b0);
      err_clr = 1'b0;
`else
      repeat (30) begin
         @(negedge mclk);
         chk1({nm, "_wait_no_done"}, h_done | s_done, 1'b0);
         chk1({nm, "_err_zero"}, err_timeout, 1'b0);
      end
      err_clr = 1'b0;
      rram_busy = 1'b1;
      @(negedge mclk);
      rram_busy = 1'b0;
      @(negedge mclk);
      chk1({nm, "_late_done"}, h_done, 1'b1);
      @(negedge mclk);
`endif
      last = 1'b0;
   endtask

   // Pulse invariants checked every cycle.
   bit pg, pd, pgo;
   always @(negedge mclk) begin
      if (rst !== 1'b0) begin
         pg = 1'b0; pd = 1'b0; pgo = 1'b0;
      end else begin
         chk1("mon_dual_gnt", h_gnt & s_gnt, 1'b0);
         chk1("mon_dual_done", h_done & s_done, 1'b0);
         chk1("mon_gnt_b2b", (h_gnt | s_gnt) & pg, 1'b0);
         chk1("mon_done_b2b", (h_done | s_done) & pd, 1'b0);
         chk1("mon_go_b2b", fsm_go & pgo, 1'b0);
         pg = h_gnt | s_gnt; pd = h_done | s_done; pgo = fsm_go;
      end
   end

   initial begin
      int gq[$];
      int ndone;
      int bcnt;
      n_chk = 0; n_fail = 0;
      do_reset();

      vec[0] = '{1, 0, mk(2, 'h0010, 'h001F, 0), mk(5, 'h0200, 'h02FF, 1), 0, mk(2, 'h0010, 'h001F, 0)};
      vec[1] = '{1, 1, mk(1, 'h0100, 'h0180, 1), mk(6, 'h4000, 'h4FFF, 0), 1, mk(6, 'h4000, 'h4FFF, 0)};
      vec[2] = '{1, 1, mk(3, 'h0000, 'h0000, 0), mk(7, 'hFFFF, 'hFFFF, 1), 0, mk(3, 'h0000, 'h0000, 0)};
      vec[3] = '{0, 1, mk(4, 'h0001, 'h0002, 1), mk(0, 'hABCD, 'h1234, 0), 1, mk(0, 'hABCD, 'h1234, 0)};
      vec[4] = '{1, 1, mk(7, 'hFFFF, 'h0000, 1), mk(1, 'h0002, 'h0003, 0), 0, mk(7, 'hFFFF, 'h0000, 1)};
      vec[5] = '{1, 0, mk(5, 'h5555, 'hAAAA, 0), mk(2, 'h0008, 'h0009, 1), 0, mk(5, 'h5555, 'hAAAA, 0)};
      vec[6] = '{0, 1, mk(6, 'h0042, 'h0043, 0), mk(3, 'h7000, 'h7100, 1), 1, mk(3, 'h7000, 'h7100, 1)};
      vec[7] = '{0, 1, mk(1, 'h0001, 'h0001, 1), mk(4, 'h0BAD, 'hF00D, 0), 1, mk(4, 'h0BAD, 'hF00D, 0)};
      for (int i = 0; i < 8; i++) begin
         run_op(vec[i].hr, vec[i].sr, vec[i].hc, vec[i].sc, vec[i].exp_own, 0, 1, 2, "tbl");
         chk_cmd("tbl_exp", vec[i].exp_cmd);
         last = vec[i].exp_own;
      end

      // Randomized transactions against the round-robin rule.
      for (int i = 0; i < 40; i++) begin
         int p;
         bit hr, sr, w;
         p  = int'($urandom_range(1, 3));
         hr = p[0];
         sr = p[1];
         w  = (hr && sr) ? !last : sr;
         run_op(hr, sr, rand_cmd(), rand_cmd(), w, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), "rnd");
         last = w;
      end

      // Both requesters held high from reset: host, scrub, host.
      do_reset();
      drive_cmds(rand_cmd(), rand_cmd());
      h_req = 1'b1; s_req = 1'b1;
      ndone = 0; bcnt = 0;
      for (int cyc = 0; cyc < 300 && ndone < 3; cyc++) begin
         @(negedge mclk);
         if (h_gnt) gq.push_back(0);
         if (s_gnt) gq.push_back(1);
         if (h_done | s_done) ndone++;
         if (gq.size() >= 3) begin
            h_req = 1'b0; s_req = 1'b0;
         end
         if (fsm_go) bcnt = 4;
         rram_busy = (bcnt > 0);
         if (bcnt > 0) bcnt--;
      end
      chkw("rr_done_count", 32'(ndone), 32'd3);
      chkw("rr_gnt_count", 32'(gq.size()), 32'd3);
      if (gq.size() == 3) begin
         chkw("rr_first", 32'(gq[0]), 32'd0);
         chkw("rr_second", 32'(gq[1]), 32'd1);
         chkw("rr_third", 32'(gq[2]), 32'd0);
      end
      @(negedge mclk);

      // Reset during RUN: no done, then pointer back to host-first.
      drive_cmds(rand_cmd(), rand_cmd());
      h_req = 1'b1;
      @(negedge mclk);
      chk1("rstrun_h_gnt", h_gnt, 1'b1);
      h_req = 1'b0;
      @(negedge mclk);
      chk1("rstrun_fsm_go", fsm_go, 1'b1);
      rram_busy = 1'b1;
      @(negedge mclk);
      rst = 1'b1;
      @(negedge mclk);
      chk_all_zero("rstrun");
      rst = 1'b0; rram_busy = 1'b0;
      repeat (4) begin
         @(negedge mclk);
         chk1("rstrun_no_done", h_done | s_done, 1'b0);
      end
      run_op(1, 1, rand_cmd(), rand_cmd(), 0, 0, 0, 2, "after_rst");
      last = 1'b0;

      // Request withdrawn before it could be sampled.
      h_req = 1'b1; rram_busy = 1'b1;
      repeat (3) begin
         @(negedge mclk);
         chk1("withdraw_busy", h_gnt, 1'b0);
      end
      h_req = 1'b0; rram_busy = 1'b0;
      repeat (3) begin
         @(negedge mclk);
         chk1("withdraw_no_gnt", h_gnt | s_gnt, 1'b0);
      end

      run_op(0, 1, rand_cmd(), rand_cmd(), 1, 10, 0, 3, "busy_idle");
      last = 1'b1;
      run_op(1, 0, mk(2, 'h0010, 'h001F, 0), rand_cmd(), 0, 0, 2, 20, "single_host");
      last = 1'b0;

      timeout_test(1'b0, "timeout");
      timeout_test(1'b1, "timeout_clr");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
